// File: rtl/toy_mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package toy_mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_LSU = 1'b1
    } gnt_idx_e;

endpackage

// File: rtl/toy_rr_arb2.sv
// Two-way round-robin picker: a lone eligible port wins, a tie goes to the
// port that did not win last.
module toy_rr_arb2
    import toy_mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] elig,
    input  gnt_idx_e             last_grant,
    output logic [NUM_PORTS-1:0] grant
);

    always_comb begin
        grant = elig;
        if (&elig)
            grant = (last_grant == GNT_IF) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/toy_mem_arbiter.sv
// Shares one zero-latency byte-enabled memory between instruction fetch and
// the load/store unit, with a registered response slot per port.
module toy_mem_arbiter
    import toy_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req_vld,
    output logic [NUM_PORTS-1:0]                  req_rdy,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0]                  req_wr_en,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wr_data,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_wr_byte_en,
    output logic [NUM_PORTS-1:0]                  rsp_vld,
    input  logic [NUM_PORTS-1:0]                  rsp_rdy,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_data,
    output logic [NUM_PORTS-1:0]                  rsp_is_wr,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_rd_data,
    output logic [DATA_WIDTH-1:0]                 mem_wr_data,
    output logic [DATA_WIDTH/8-1:0]               mem_wr_byte_en,
    output logic                                  mem_wr_en
);

    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [NUM_PORTS-1:0] grant;
    logic                 win;
    gnt_idx_e             last_grant;

    // A port may issue only when its response slot is empty or draining now.
    assign elig = req_vld & (~rsp_vld | rsp_rdy);

    toy_rr_arb2 u_arb (
        .elig       (elig),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    assign grant   = rst ? '0 : arb_grant;
    assign req_rdy = grant;
    assign win     = grant[1];

    always_comb begin
        mem_addr       = '0;
        mem_wr_data    = '0;
        mem_wr_byte_en = '0;
        mem_wr_en      = 1'b0;
        if (|grant) begin
            mem_addr       = req_addr[win];
            mem_wr_data    = req_wr_data[win];
            mem_wr_byte_en = req_wr_byte_en[win];
            mem_wr_en      = req_wr_en[win];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GNT_LSU;
        else if (|grant)
            last_grant <= win ? GNT_LSU : GNT_IF;
    end

    // A grant reloads the slot even while it drains, sustaining 1 req/cycle.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_vld[i]   <= 1'b0;
                rsp_is_wr[i] <= 1'b0;
                rsp_data[i]  <= '0;
            end else if (grant[i]) begin
                rsp_vld[i]   <= 1'b1;
                rsp_is_wr[i] <= req_wr_en[i];
                rsp_data[i]  <= req_wr_en[i] ? '0 : mem_rd_data;
            end else if (rsp_rdy[i]) begin
                rsp_vld[i]   <= 1'b0;
            end
        end
    end

endmodule
